addr_inc_sequencer: RTL and testbench
=====================================

Name: addr_inc_sequencer

Overview:
- Address-bus incrementer plus its control sequencer; sits directly downstream of the address-bus registers (PC, XY).
- On request it performs one of two operations:
  - Fetch-increment: PC is placed on the address bus, memory is read into the instruction register, and PC+1 is written back to PC.
  - XY-increment: XY is placed on the bus and XY+1 is written back to XY.
- Generates the load/sel strobes consumed by the address registers, the memory read strobe, and the Inc register's bus-drive enable.

Parameters:
- N, 16, address-bus and Inc register width.
- MEM_WAIT, 2, cycles mem_rd/load_inst are held during fetch (legal range 1..15).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- op  input  1  0 = fetch-increment (PC), 1 = XY-increment.
- addr_in  input  N  resolved address-bus value read back from the bus.
- addr_out  output  N  Inc register value offered to the bus.
- addr_drive  output  1  bus-drive enable for addr_out (Inc register sel).
- sel_pc  output  1  PC register drives the address bus.
- sel_xy  output  1  XY register drives the address bus.
- load_pc  output  1  PC register loads from the address bus.
- load_xy  output  1  XY register loads from the address bus.
- mem_rd  output  1  memory read strobe.
- load_inst  output  1  instruction register load strobe.
- busy  output  1  high from the cycle after an accepted start until DONE is left.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset values: state = IDLE, inc_reg = 0, wait counter = 0, op_q = 0, every output 0 (addr_out = 0).
- Controls are Moore outputs decoded from state and op_q only.
- States and transitions:
  - IDLE: all strobes 0. start = 1 latches op into op_q; next state SRC.
  - SRC: sel_pc = ~op_q, sel_xy = op_q. inc_reg <= addr_in + 1 at the end of the cycle.
    - Next state is MEM if op_q = 0.
    - Next state is WB if op_q = 1.
  - MEM (fetch only): sel_pc = 1, mem_rd = 1, load_inst = 1, held for exactly MEM_WAIT cycles. The counter loads MEM_WAIT-1 on entry and decrements; at 0 the next state is WB.
  - WB: addr_drive = 1, addr_out = inc_reg. load_pc = ~op_q, load_xy = op_q. Next state DONE.
  - DONE: done = 1, busy = 1, all strobes 0. Next state IDLE.
- Latency, start to done pulse:
  - Fetch-increment: 3 + MEM_WAIT cycles.
  - XY-increment: 3 cycles.
- Bus exclusivity: addr_drive, sel_pc and sel_xy are never high in the same cycle.
- Load exclusivity: load_pc and load_xy are never high in the same cycle.
- Arithmetic: the increment is modulo 2^N. 0xFFFF + 1 gives 0x0000, with no error and no stall.
- Boundary conditions:
  - start while busy: ignored, no queuing.
  - start and reset in the same cycle: reset wins.
  - Reset mid-operation: next cycle is IDLE with all strobes low. A partially completed PC/XY write-back never occurs.
  - A change on op after the cycle in which start was accepted has no effect (op_q is used).
  - addr_in is sampled only in SRC and ignored in all other states.

Optional Feature:
- Macro: INC_CARRY_EN.
- Defined:
  - Adds output port carry (1 bit).
  - In SRC, carry_q <= (addr_in == all ones). carry is driven from carry_q and holds until the next SRC.
  - carry resets to 0.
- Undefined: no carry port and no extra flop. All other behaviour is identical.

Test Plan:
- Reset, then 5 idle cycles -> all outputs 0, busy = 0, addr_out = 0x0000.
- start, op = 0, bus returns 0x1234 in SRC, MEM_WAIT = 2 -> sel_pc for 3 cycles, mem_rd/load_inst for 2 cycles, then WB with addr_out = 0x1235, addr_drive = 1, load_pc = 1; done on cycle 5 after start.
- start, op = 1, bus returns 0xFFFF -> sel_xy 1 cycle, WB addr_out = 0x0000 with load_xy = 1, done on cycle 3; with INC_CARRY_EN, carry = 1.
- start pulsed again during MEM of a fetch -> ignored; exactly one done pulse, and the next start is accepted only after IDLE.
- reset asserted during MEM -> next cycle IDLE; load_pc never pulses; inc_reg = 0.
- Back-to-back XY-increments from 0x00FE, start reasserted in the cycle after done -> write-back values 0x00FF then 0x0100; strobe exclusivity assertions hold throughout.

Source files
------------

// File: rtl/addr_inc_sequencer.sv
// Address-bus incrementer and its control sequencer for the PC/XY registers.
// Ports: clk, reset (sync, active-high), start/op request, addr_in bus readback;
//   addr_out/addr_drive (Inc register onto bus), sel_pc/sel_xy, load_pc/load_xy,
//   mem_rd, load_inst, busy, done. Optional carry output under `INC_CARRY_EN.
module addr_inc_sequencer #(
  parameter int N        = 16,
  parameter int MEM_WAIT = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         op,
  input  logic [N-1:0] addr_in,
  output logic [N-1:0] addr_out,
  output logic         addr_drive,
  output logic         sel_pc,
  output logic         sel_xy,
  output logic         load_pc,
  output logic         load_xy,
  output logic         mem_rd,
  output logic         load_inst,
  output logic         busy,
  output logic         done
`ifdef INC_CARRY_EN
  ,
  output logic         carry
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SRC,
    S_MEM,
    S_WB,
    S_DONE
  } state_t;

  // MEM is entered with MEM_WAIT-1 and left when the counter reads 0,
  // so MEM lasts exactly MEM_WAIT cycles (MEM_WAIT must be 1..15).
  localparam logic [3:0] MW_M1 = 4'(MEM_WAIT - 1);

  state_t       state_q, state_d;
  logic         op_q, op_d;
  logic [N-1:0] inc_q, inc_d;
  logic [3:0]   cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= 1'b0;
      inc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      inc_q   <= inc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    inc_d   = inc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          state_d = S_SRC;
        end
      end
      S_SRC: begin
        // Wraps modulo 2^N with no special handling.
        inc_d = addr_in + N'(1);
        if (op_q) begin
          state_d = S_WB;
        end else begin
          state_d = S_MEM;
          cnt_d   = MW_M1;
        end
      end
      S_MEM: begin
        if (cnt_q == 4'd0) begin
          state_d = S_WB;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_WB:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_out   = '0;
    addr_drive = 1'b0;
    sel_pc     = 1'b0;
    sel_xy     = 1'b0;
    load_pc    = 1'b0;
    load_xy    = 1'b0;
    mem_rd     = 1'b0;
    load_inst  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
      end
      S_SRC: begin
        busy   = 1'b1;
        sel_pc = ~op_q;
        sel_xy = op_q;
      end
      S_MEM: begin
        busy      = 1'b1;
        sel_pc    = 1'b1;
        mem_rd    = 1'b1;
        load_inst = 1'b1;
      end
      S_WB: begin
        busy       = 1'b1;
        addr_drive = 1'b1;
        addr_out   = inc_q;
        load_pc    = ~op_q;
        load_xy    = op_q;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

`ifdef INC_CARRY_EN
  logic carry_q, carry_d;

  always_ff @(posedge clk) begin
    if (reset) carry_q <= 1'b0;
    else       carry_q <= carry_d;
  end

  // Captured only in SRC, held until the next SRC.
  always_comb begin
    carry_d = carry_q;
    if (state_q == S_SRC) carry_d = &addr_in;
  end

  assign carry = carry_q;
`endif

endmodule

// File: tb/tb_addr_inc_sequencer.sv
// Scoreboard bench for addr_inc_sequencer.
// Stimulus pushes expected write-back/done records; a monitor pops and checks.
module tb_addr_inc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [15:0] addr_in;
  logic [15:0] addr_out;
  logic        addr_drive, sel_pc, sel_xy, load_pc, load_xy;
  logic        mem_rd, load_inst, busy, done;
`ifdef INC_CARRY_EN
  logic        carry;
`endif

  logic [15:0] src_val;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [15:0] wb;
    logic        op;
    int          done_cyc;
    int          n_pc;
    int          n_xy;
    int          n_mem;
  } exp_t;

  exp_t q[$];

  addr_inc_sequencer #(.N(16), .MEM_WAIT(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .addr_in    (addr_in),
    .addr_out   (addr_out),
    .addr_drive (addr_drive),
    .sel_pc     (sel_pc),
    .sel_xy     (sel_xy),
    .load_pc    (load_pc),
    .load_xy    (load_xy),
    .mem_rd     (mem_rd),
    .load_inst  (load_inst),
    .busy       (busy),
    .done       (done)
`ifdef INC_CARRY_EN
    ,
    .carry      (carry)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Bus model: the selected source register, else the Inc register, else junk.
  always_comb begin
    if (sel_pc || sel_xy) addr_in = src_val;
    else if (addr_drive)  addr_in = addr_out;
    else                  addr_in = 16'h5A5A;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  int n_pc = 0, n_xy = 0, n_mem = 0, n_inst = 0, n_ld = 0;

  always @(negedge clk) begin
    exp_t e;
    if (reset !== 1'b1) begin
      chk("bus_excl", 32'(int'(addr_drive) + int'(sel_pc) + int'(sel_xy) <= 1), 1);
      chk("load_excl", 32'(load_pc & load_xy), 0);
      if (!busy) begin
        n_pc = 0; n_xy = 0; n_mem = 0; n_inst = 0; n_ld = 0;
      end else begin
        n_pc   += int'(sel_pc);
        n_xy   += int'(sel_xy);
        n_mem  += int'(mem_rd);
        n_inst += int'(load_inst);
        n_ld   += int'(load_pc) + int'(load_xy);
      end
      if (addr_drive) begin
        if (q.size() == 0) chk("unexpected_wb", 32'(addr_drive), 0);
        else begin
          e = q[0];
          chk("wb_addr", 32'(addr_out), 32'(e.wb));
          chk("wb_load_pc", 32'(load_pc), 32'(!e.op));
          chk("wb_load_xy", 32'(load_xy), 32'(e.op));
          chk("wb_cycle", 32'(cyc), 32'(e.done_cyc - 1));
        end
      end
      if (done) begin
        if (q.size() == 0) chk("unexpected_done", 32'(done), 0);
        else begin
          e = q.pop_front();
          chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
          chk("done_busy", 32'(busy), 1);
          chk("n_sel_pc", 32'(n_pc), 32'(e.n_pc));
          chk("n_sel_xy", 32'(n_xy), 32'(e.n_xy));
          chk("n_mem_rd", 32'(n_mem), 32'(e.n_mem));
          chk("n_load_inst", 32'(n_inst), 32'(e.n_mem));
          chk("n_loads", 32'(n_ld), 1);
        end
      end
    end
  end

  function automatic logic [25:0] all_outs();
    return {addr_out, addr_drive, sel_pc, sel_xy, load_pc, load_xy,
            mem_rd, load_inst, busy, done};
  endfunction

  task automatic run_op(input logic o, input logic [15:0] src,
                        input logic [15:0] wb, input int lat,
                        input int pulse_at, input int e_pc,
                        input int e_xy, input int e_mem);
    exp_t e;
    src_val = src;
    op      = o;
    start   = 1'b1;
    e.wb = wb; e.op = o; e.done_cyc = cyc + lat;
    e.n_pc = e_pc; e.n_xy = e_xy; e.n_mem = e_mem;
    q.push_back(e);
    for (int k = 1; k <= lat + 6; k++) begin
      @(negedge clk); #1;
      start = (k == pulse_at);
      op    = ~o;
      if (q.size() == 0) break;
    end
    if (q.size() != 0) begin
      chk("timeout_pending", 32'(q.size()), 0);
      q.delete();
    end
    @(negedge clk); #1;
    if (pulse_at == lat) chk("start_in_done_ignored", 32'(busy), 0);
    start = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    op      = 1'b0;
    src_val = 16'h0000;
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("idle_outputs", 32'(all_outs()), 0);
    end

    run_op(1'b0, 16'h1234, 16'h1235, 5, 0, 3, 0, 2);
`ifdef INC_CARRY_EN
    chk("carry_clear", 32'(carry), 0);
`endif
    run_op(1'b1, 16'hFFFF, 16'h0000, 3, 0, 0, 1, 0);
`ifdef INC_CARRY_EN
    chk("carry_set", 32'(carry), 1);
`endif
    run_op(1'b0, 16'h2000, 16'h2001, 5, 2, 3, 0, 2);
    run_op(1'b0, 16'h3000, 16'h3001, 5, 5, 3, 0, 2);

    src_val = 16'h4444;
    op      = 1'b0;
    start   = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    chk("src_sel_pc", 32'(sel_pc), 1);
    @(negedge clk); #1;
    chk("mem_rd_before_reset", 32'(mem_rd), 1);
    reset = 1'b1;
    @(negedge clk); #1;
    chk("reset_mid_op_outputs", 32'(all_outs()), 0);
    reset = 1'b0;
    repeat (6) begin
      @(negedge clk); #1;
      chk("post_reset_idle", 32'(busy), 0);
    end

    op    = 1'b1;
    start = 1'b1;
    reset = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    reset = 1'b0;
    chk("reset_wins_busy", 32'(busy), 0);
    chk("reset_wins_sel_xy", 32'(sel_xy), 0);
    @(negedge clk); #1;

    run_op(1'b1, 16'h00FE, 16'h00FF, 3, 0, 0, 1, 0);
    run_op(1'b1, 16'h00FF, 16'h0100, 3, 0, 0, 1, 0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
